// File: rtl/gpio_window_capture.sv
// Snoops GPIO writes, captures in-window {offset, data} into a FIFO and streams them out.
// Latency: hit on cycle N is visible on out_valid at N+1 (registered FIFO, no comb path from inputs).
// Backpressure: out_ready low holds the head entry; a hit into a full FIFO without a pop is dropped and flagged.
module gpio_window_capture #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 32,
    parameter int WIN_LO   = 152100,
    parameter int WIN_HI   = 304199,
    parameter int DEPTH    = 16,
    parameter int MAX_CAPT = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] GPIOaddr,
    input  logic [DATA_W-1:0] GPIO,
    input  logic              GPIOEn,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       capt_cnt,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LO_A  = ADDR_W'(WIN_LO);
    localparam logic [ADDR_W-1:0] HI_A  = ADDR_W'(WIN_HI);
    localparam logic [31:0]       MAX_C = 32'(MAX_CAPT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic [31:0]       capt_cnt_q, capt_cnt_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] dat_mem_q [DEPTH];
    logic [ADDR_W-1:0] off_mem_q [DEPTH];

    logic              fifo_empty;
    logic              fifo_full;
    logic              in_win;
    logic              hit;
    logic              pop;
    logic              armed_hit;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] hit_off;

    // FIFO status, window decode and push/pop qualification
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
        in_win     = (GPIOaddr >= LO_A) && (GPIOaddr <= HI_A);
        hit        = GPIOEn && in_win;
        pop        = !fifo_empty && out_ready;
        armed_hit  = (state_q == S_ARMED) && hit;
        // A full FIFO still takes the hit when the head leaves on the same edge.
        push       = armed_hit && (!fifo_full || pop);
        drop       = armed_hit && fifo_full && !pop;
        hit_off    = GPIOaddr - LO_A;
    end

    // Next-state: run control, capture counter, sticky overflow, FIFO pointers
    always_comb begin
        state_d    = state_q;
        capt_cnt_d = capt_cnt_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ARMED;
                    capt_cnt_d = 32'd0;
                    overflow_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (push) begin
                    capt_cnt_d = capt_cnt_q + 32'd1;
                    if ((MAX_C != 32'd0) && (capt_cnt_q + 32'd1 == MAX_C)) begin
                        state_d = S_DRAIN;
                    end
                end
                if (drop) begin
                    overflow_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    // State and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            capt_cnt_q <= 32'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            capt_cnt_q <= capt_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push) begin
            dat_mem_q[wr_ptr_q[PW-1:0]] <= GPIO;
            off_mem_q[wr_ptr_q[PW-1:0]] <= hit_off;
        end
    end

    // Outputs: head entry shown only while valid so idle/reset values read as zero
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = fifo_empty ? '0 : dat_mem_q[rd_ptr_q[PW-1:0]];
        out_off   = fifo_empty ? '0 : off_mem_q[rd_ptr_q[PW-1:0]];
        capt_cnt  = capt_cnt_q;
        busy      = (state_q == S_ARMED) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_gpio_window_capture.sv
// Directed bench for gpio_window_capture with a queue-based reference model.
// Model advances on posedge; DUT outputs are compared against it on every negedge.
// Stimulus changes only on negedge, so DUT and model sample identical inputs.
module tb_gpio_window_capture;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] GPIOaddr = 32'd0;
    logic [7:0]  GPIO = 8'd0;
    logic        GPIOEn = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [31:0] out_off;
    logic        out_valid;
    logic [31:0] capt_cnt;
    logic        busy;
    logic        done;
    logic        overflow;

    gpio_window_capture #(
        .DATA_W   (8),
        .ADDR_W   (32),
        .WIN_LO   (152100),
        .WIN_HI   (304199),
        .DEPTH    (DEPTH),
        .MAX_CAPT (25)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .GPIOaddr  (GPIOaddr),
        .GPIO      (GPIO),
        .GPIOEn    (GPIOEn),
        .out_data  (out_data),
        .out_off   (out_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .capt_cnt  (capt_cnt),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] off;
        logic [7:0]  dat;
    } ent_t;

    ent_t        mq[$];
    int          m_phase = 0;     // 0 idle, 1 capturing, 2 draining, 3 finished
    int unsigned m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_pop;
    bit          m_hit;
    bit          m_acc;
    int          m_sz;
    ent_t        m_e;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_phase = 0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
        end else begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && out_ready;
            m_hit = GPIOEn && (GPIOaddr >= 32'd152100) && (GPIOaddr <= 32'd304199);
            m_acc = 1'b0;
            if (m_phase == 0 || m_phase == 3) begin
                if (start) begin
                    m_phase = 1;
                    m_cnt   = 0;
                    m_ovf   = 1'b0;
                end
            end else if (m_phase == 1) begin
                if (m_hit) begin
                    if (m_sz < DEPTH || m_pop) begin
                        m_acc = 1'b1;
                        m_cnt = m_cnt + 1;
                        if (m_cnt == 25) m_phase = 2;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end else begin
                if (m_sz == 0) m_phase = 3;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                m_e.off = GPIOaddr - 32'd152100;
                m_e.dat = GPIO;
                mq.push_back(m_e);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", out_valid, (mq.size() > 0));
            if (mq.size() > 0) begin
                chk("m_data", out_data, mq[0].dat);
                chk("m_off",  out_off,  mq[0].off);
            end
            chk("m_cnt",  capt_cnt, m_cnt);
            chk("m_busy", busy, (m_phase == 1 || m_phase == 2));
            chk("m_done", done, (m_phase == 3));
            chk("m_ovf",  overflow, m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input int a, input int d, input bit en);
        logic [31:0] dv;
        dv       = d;
        GPIOaddr = a;
        GPIO     = dv[7:0];
        GPIOEn   = en;
        tick();
        GPIOEn   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        i = 0;
        while (!done && i < 500) begin
            tick();
            i++;
        end
        chk(nm, done, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int pk;

        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data,  0);
        chk("rst_off",   out_off,   0);
        chk("rst_cnt",   capt_cnt,  0);
        chk("rst_busy",  busy,      0);
        chk("rst_done",  done,      0);
        chk("rst_ovf",   overflow,  0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick();

        // hits while idle are ignored
        for (int k = 1; k <= 3; k++) wr(152100 + k, k, 1'b1);
        tick();
        chk("idle_cnt",   capt_cnt,  0);
        chk("idle_valid", out_valid, 0);

        // full run of 25 captures streamed out immediately
        pulse_start();
        out_ready = 1'b1;
        pk = 0;
        for (int k = 0; k < 25; k++) begin
            wr(152100 + k, k, 1'b1);
            if (out_valid) begin
                chk("t1_off", out_off,  pk);
                chk("t1_dat", out_data, pk);
                pk++;
            end
        end
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (out_valid) begin
                chk("t1_off", out_off,  pk);
                chk("t1_dat", out_data, pk);
                pk++;
            end
        end
        wait_done("t1_done");
        chk("t1_npop", pk, 25);
        chk("t1_cnt",  capt_cnt, 25);

        // hits after done are ignored
        for (int k = 1; k <= 3; k++) wr(152100 + k, k, 1'b1);
        tick();
        chk("post_cnt",   capt_cnt,  25);
        chk("post_valid", out_valid, 0);

        // restart from DONE clears status
        pulse_start();
        chk("rs_cnt",  capt_cnt, 0);
        chk("rs_done", done,     0);
        chk("rs_busy", busy,     1);

        // window edges and disabled write
        wr(152099, 1, 1'b1);
        wr(304200, 2, 1'b1);
        wr(152100, 3, 1'b0);
        tick();
        chk("t2_cnt",   capt_cnt,  0);
        chk("t2_valid", out_valid, 0);

        // overflow: 17 hits with consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) wr(152100 + k, k, 1'b1);
        chk("t3_ovf",   overflow,  1);
        chk("t3_cnt",   capt_cnt,  16);
        chk("t3_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("t3_off", out_off,  k);
            chk("t3_dat", out_data, k);
            tick();
        end
        chk("t3_empty", out_valid, 0);
        for (int k = 0; k < 9; k++) wr(152100 + 200 + k, k, 1'b1);
        wait_done("t3_done");
        chk("t3_ovf_sticky", overflow, 1);

        // full FIFO with simultaneous hit and pop
        pulse_start();
        chk("t4_ovf_clr", overflow, 0);
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) wr(152100 + k, 8'h40 + k, 1'b1);
        chk("t4_full_cnt", capt_cnt, 16);
        GPIOaddr  = 152100 + 99;
        GPIO      = 8'hAA;
        GPIOEn    = 1'b1;
        out_ready = 1'b1;
        tick();
        GPIOEn    = 1'b0;
        out_ready = 1'b0;
        chk("t4_cnt",  capt_cnt, 17);
        chk("t4_ovf",  overflow, 0);
        chk("t4_head", out_data, 8'h41);

        // reset mid-run discards buffered entries
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_start();
        for (int k = 0; k < 5; k++) wr(152100 + k, 8'h10 + k, 1'b1);
        chk("t6_pre_cnt", capt_cnt, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", out_valid, 0);
        chk("t6_cnt",   capt_cnt,  0);
        chk("t6_busy",  busy,      0);
        pulse_start();
        wr(152100 + 7, 8'h55, 1'b1);
        wr(152100 + 8, 8'h56, 1'b1);
        chk("t6_dat0", out_data, 8'h55);
        chk("t6_off0", out_off,  7);
        out_ready = 1'b1;
        tick();
        chk("t6_dat1", out_data, 8'h56);
        chk("t6_off1", out_off,  8);
        tick();
        chk("t6_empty", out_valid, 0);
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
